simpleadder_host: RTL and testbench

SIMPLEADDER_HOST -- requirements
Module: simpleadder_host

---
 rtl/simpleadder_pkg.sv | 19 +
 rtl/simpleadder_host_if.sv | 25 ++
 rtl/simpleadder_host.sv | 112 +++++++++++
 tb/tb_simpleadder_host.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/simpleadder_pkg.sv
// Shared types and constants for the simpleadder host.
// Operand/result widths, FSM state encoding and the default WAIT timeout.
package simpleadder_pkg;

    localparam int OPW                = 2;
    localparam int RESW               = 3;
    localparam int TIMEOUT_CYCLES_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        SEND0,
        SEND1,
        WAIT,
        RECV1,
        RECV2,
        HOLD
    } state_t;

endpackage

// File: rtl/simpleadder_host_if.sv
// Operand-in / result-out handshake bundle between a client and the host.
// master drives operands and res_ready; slave (the host) drives the rest.
interface simpleadder_host_if;
    import simpleadder_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  in_a;
    logic [OPW-1:0]  in_b;
    logic            res_valid;
    logic            res_ready;
    logic [RESW-1:0] res_data;
    logic            res_err;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, res_err
    );

endinterface

// File: rtl/simpleadder_host.sv
// Serialises an operand pair MSB-first to simpleadder and collects its 3-bit serial sum.
// Latency: accept cycle to res_valid is 7 cycles against simpleadder (11 on timeout).
// Backpressure: in_ready only in IDLE; the result is held in HOLD until res_ready.
module simpleadder_host
    import simpleadder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    simpleadder_host_if.slave   hif,
    output logic                en_o,
    output logic                ina_o,
    output logic                inb_o,
    input  logic                en_i,
    input  logic                outp_i
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t          state;
    logic            a_lsb;
    logic            b_lsb;
    logic [CW-1:0]   tmo_cnt;
    logic            in_ready_q;
    logic            res_valid_q;
    logic [RESW-1:0] res_data_q;
    logic            res_err_q;

    assign hif.in_ready  = in_ready_q;
    assign hif.res_valid = res_valid_q;
    assign hif.res_data  = res_data_q;
    assign hif.res_err   = res_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_lsb       <= 1'b0;
            b_lsb       <= 1'b0;
            tmo_cnt     <= '0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            en_o        <= 1'b0;
            ina_o       <= 1'b0;
            inb_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready_q && hif.in_valid) begin
                        // MSBs go straight to the wire; only the LSBs need keeping
                        a_lsb      <= hif.in_a[0];
                        b_lsb      <= hif.in_b[0];
                        en_o       <= 1'b1;
                        ina_o      <= hif.in_a[OPW-1];
                        inb_o      <= hif.in_b[OPW-1];
                        in_ready_q <= 1'b0;
                        state      <= SEND0;
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                SEND0: begin
                    en_o  <= 1'b0;
                    ina_o <= a_lsb;
                    inb_o <= b_lsb;
                    state <= SEND1;
                end
                SEND1: begin
                    ina_o   <= 1'b0;
                    inb_o   <= 1'b0;
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (en_i) begin
                        res_data_q[2] <= outp_i;
                        state         <= RECV1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        res_data_q  <= '0;
                        res_err_q   <= 1'b1;
                        res_valid_q <= 1'b1;
                        state       <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RECV1: begin
                    res_data_q[1] <= outp_i;
                    state         <= RECV2;
                end
                RECV2: begin
                    res_data_q[0] <= outp_i;
                    res_err_q     <= 1'b0;
                    res_valid_q   <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: begin
                    if (hif.res_ready) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simpleadder_host.sv
// Randomised bench for simpleadder_host with a behavioural serial adder attached.
module tb_simpleadder_host;

    logic clk = 1'b0;
    logic rst_n;
    logic en_o, ina_o, inb_o, en_i, outp_i;

    logic adder_on = 1'b1;
    logic mdl_en   = 1'b0;
    logic mdl_outp = 1'b0;
    logic spur_en  = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign en_i   = mdl_en | spur_en;
    assign outp_i = mdl_outp;

    simpleadder_host_if hif ();

    simpleadder_host #(.TIMEOUT_CYCLES(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .hif    (hif),
        .en_o   (en_o),
        .ina_o  (ina_o),
        .inb_o  (inb_o),
        .en_i   (en_i),
        .outp_i (outp_i)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Serial adder: takes two MSB-first bits after en_o, answers with en + 3 sum bits
    // starting three cycles after the en_o cycle.
    initial begin
        logic [1:0] ma, mb;
        logic [2:0] ms;
        forever begin
            @(negedge clk);
            if (adder_on && rst_n && en_o) begin
                ma[1] = ina_o; mb[1] = inb_o;
                @(negedge clk);
                ma[0] = ina_o; mb[0] = inb_o;
                ms = 3'(ma) + 3'(mb);
                @(posedge clk);
                @(posedge clk); #1 mdl_en = 1'b1; mdl_outp = ms[2];
                @(posedge clk); #1 mdl_en = 1'b0; mdl_outp = ms[1];
                @(posedge clk); #1 mdl_outp = ms[0];
                @(posedge clk); #1 mdl_outp = 1'b0;
            end
        end
    end

    task automatic do_op(input logic [1:0] a, input logic [1:0] b, input bit spur,
                         input int hold, input int exp_lat, input logic exp_err,
                         input logic [2:0] exp_data);
        int k;
        k = 0;
        while (hif.in_ready !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk_eq("in_ready_wait", 32'(hif.in_ready), 32'd1);
        hif.in_valid = 1'b1; hif.in_a = a; hif.in_b = b;
        @(posedge clk); #1;
        hif.in_valid = 1'b0; hif.in_a = 2'($urandom); hif.in_b = 2'($urandom);
        spur_en = spur;
        @(negedge clk);
        chk_eq("send0", 32'({en_o, ina_o, inb_o, hif.in_ready}), 32'({1'b1, a[1], b[1], 1'b0}));
        @(posedge clk); #1 spur_en = 1'b0;
        @(negedge clk);
        chk_eq("send1", 32'({en_o, ina_o, inb_o}), 32'({1'b0, a[0], b[0]}));
        k = 2;
        while (hif.res_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
            if (en_o !== 1'b0) chk_eq("en_o_idle", 32'(en_o), 32'd0);
        end
        chk_eq("latency", 32'(k), 32'(exp_lat));
        chk_eq("result", 32'({hif.res_err, hif.res_data}), 32'({exp_err, exp_data}));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            hif.in_valid = 1'($urandom);
            spur_en      = 1'($urandom);
            @(negedge clk);
            chk_eq("hold_stable", 32'({hif.res_valid, hif.res_err, hif.res_data, hif.in_ready}),
                   32'({1'b1, exp_err, exp_data, 1'b0}));
        end
        @(posedge clk); #1;
        hif.in_valid = 1'b0; spur_en = 1'b0; hif.res_ready = 1'b1;
        @(posedge clk); #1 hif.res_ready = 1'b0;
        @(negedge clk);
        chk_eq("released", 32'({hif.res_valid, hif.in_ready}), 32'({1'b0, 1'b1}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ra, rb;
        rst_n = 1'b0;
        hif.in_valid = 1'b0; hif.in_a = '0; hif.in_b = '0; hif.res_ready = 1'b0;
        #23;
        chk_eq("reset_outputs",
               32'({en_o, ina_o, inb_o, hif.in_ready, hif.res_valid, hif.res_err, hif.res_data}), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk_eq("ready_after_reset", 32'(hif.in_ready), 32'd1);

        do_op(2'd3, 2'd3, 1'b0, 0, 7, 1'b0, 3'b110);
        do_op(2'd2, 2'd1, 1'b0, 1, 7, 1'b0, 3'b011);
        do_op(2'd1, 2'd2, 1'b0, 5, 7, 1'b0, 3'b011);
        do_op(2'd0, 2'd0, 1'b0, 0, 7, 1'b0, 3'b000);

        // No adder response: WAIT must time out with an error result.
        adder_on = 1'b0;
        do_op(2'd2, 2'd3, 1'b0, 3, 11, 1'b1, 3'b000);
        adder_on = 1'b1;
        spur_en = 1'b1;
        @(negedge clk);
        spur_en = 1'b0;
        @(negedge clk);
        chk_eq("stray_en_idle", 32'({en_o, hif.res_valid, hif.in_ready}), 32'({1'b0, 1'b0, 1'b1}));

        // Spurious strobe during SEND0 must not start reception.
        do_op(2'd3, 2'd1, 1'b1, 0, 7, 1'b0, 3'b100);

        // Abort in RECV1 with reset, then a clean frame.
        hif.in_valid = 1'b1; hif.in_a = 2'd3; hif.in_b = 2'd2;
        @(posedge clk); #1 hif.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("midframe_reset",
               32'({en_o, ina_o, inb_o, hif.in_ready, hif.res_valid, hif.res_err, hif.res_data}), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("ready_after_abort", 32'(hif.in_ready), 32'd1);
        do_op(2'd1, 2'd2, 1'b0, 0, 7, 1'b0, 3'b011);

        for (int n = 0; n < 20; n++) begin
            ra = 2'($urandom);
            rb = 2'($urandom);
            do_op(ra, rb, 1'($urandom), int'($urandom_range(0, 3)), 7, 1'b0, 3'(ra) + 3'(rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
